dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the data-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the data-memory word width.
REQ-003 The block SHALL provide these ports, fixed at four core requesters:
- clk  input  1  -- single clock; all state on rising edge.
- RESET  input  1  -- asynchronous, active-low reset.
- req  input  4  -- per-core access request; held until gnt.
- we  input  4  -- per-core write (1) or read (0); stable while req is high.
- addr_bus  input  4*ADDR_W  -- core k address at bits [k*ADDR_W +: ADDR_W].
- wdata_bus  input  4*DATA_W  -- core k write data, packed the same way.
- gnt  output  4  -- one-cycle accept pulse to the winning core.
- rvalid  output  4  -- one-cycle completion pulse (read data or write acknowledge).
- rdata  output  DATA_W  -- read data, shared by all cores; qualified by rvalid.
- tb_req, tb_we  input  1 each  -- testbench port request and write.
- tb_addr  input  ADDR_W  -- testbench port address.
- tb_wdata  input  DATA_W  -- testbench port write data.
- tb_gnt, tb_rvalid  output  1 each  -- testbench port grant and completion.
- mem_addr  output  ADDR_W  -- data-memory address.
- mem_wdata  output  DATA_W  -- data-memory write data.
- mem_write, mem_read  output  1 each  -- data-memory strobes.
- mem_rdata  input  DATA_W  -- data-memory output; valid the cycle after mem_read.
- busy  output  1  -- high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-005 In IDLE, if any request is high, the block SHALL latch the winner's id, we, addr and wdata and go to ACCESS on the next edge; otherwise it SHALL stay in IDLE.
REQ-006 In ACCESS (one cycle), the block SHALL assert gnt[winner] (or tb_gnt), drive mem_addr and mem_wdata from the latched values, and assert exactly one of mem_write or mem_read, then go to RESP.
REQ-007 In RESP (one cycle), the block SHALL register mem_rdata into rdata when the access is a read, then go to IDLE.
REQ-008 In the cycle after RESP, the block SHALL pulse rvalid[winner] (or tb_rvalid) for one cycle; for writes, rdata SHALL hold its previous value.
REQ-009 A request seen in IDLE at cycle T SHALL produce the grant at T+1 and completion at T+3; a new arbitration SHALL be allowed in the T+3 cycle, giving one access per 3 cycles.
REQ-010 Core arbitration SHALL be round-robin: search starts at (last_core_winner+1) mod 4 and wraps past core 3 to core 0.
REQ-011 A core whose req drops before its grant SHALL receive no access.
REQ-012 Requests arriving outside IDLE SHALL be ignored until the next IDLE cycle.
REQ-013 The block SHALL never produce more than one gnt/tb_gnt bit, or more than one rvalid/tb_rvalid bit, in the same cycle.
REQ-014 mem_write and mem_read SHALL be 0 in every state except ACCESS; mem_addr and mem_wdata SHALL hold their last values outside ACCESS.

Reset
REQ-015 While RESET is low, the block SHALL immediately force state=IDLE, round-robin pointer=0 (core 0 has highest priority), and all outputs to zero.
REQ-016 Reset asserted mid-transaction SHALL abort the transaction: no strobe, grant or rvalid for it after RESET is released.

Configuration
REQ-017 With macro DMEM_ARB_TB_PORT_EN defined, the testbench port SHALL have absolute priority over all cores in IDLE, and a testbench win SHALL NOT change the round-robin pointer.
REQ-018 With DMEM_ARB_TB_PORT_EN undefined, the block SHALL ignore tb_req, tb_we, tb_addr and tb_wdata, and SHALL tie tb_gnt and tb_rvalid to 0.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Assert RESET low mid-run -> all outputs 0 and busy=0 within the same cycle.
- Core 1 writes 0xABCD to 0x0010, then reads 0x0010 -> mem_write at T+1, rvalid[1] at T+3; on the read, rdata=0xABCD with rvalid[1].
- req=4'b1111 held after reset -> gnt order 0,1,2,3, grants 3 cycles apart.
- Cores 0 and 2 hold req continuously -> grants alternate 0,2,0,2; cores 1 and 3 are never granted.
- tb_req and req[3] together, macro defined -> tb_gnt first, then gnt[3]; macro undefined -> gnt[3] only, tb_gnt stays 0.
- RESET low during ACCESS of a core 2 read -> mem_read drops immediately; no rvalid[2] after RESET is released.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port among four cores using round-robin
// arbitration, one access every three cycles (IDLE -> ACCESS -> RESP).
// Optional feature macro: DMEM_ARB_TB_PORT_EN -- enables a testbench port with
// absolute priority over the cores; when undefined the port is ignored and its
// outputs are tied low.
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  RESET,
   input  logic [3:0]            req,
   input  logic [3:0]            we,
   input  logic [4*ADDR_W-1:0]   addr_bus,
   input  logic [4*DATA_W-1:0]   wdata_bus,
   output logic [3:0]            gnt,
   output logic [3:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   input  logic                  tb_req,
   input  logic                  tb_we,
   input  logic [ADDR_W-1:0]     tb_addr,
   input  logic [DATA_W-1:0]     tb_wdata,
   output logic                  tb_gnt,
   output logic                  tb_rvalid,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        r_rr_ptr;
   logic [1:0]        r_id;
   logic              r_is_tb;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [3:0]        r_rvalid;
   logic              r_tb_rvalid;

   logic              w_found;
   logic [1:0]        w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_tb_win;
   logic              w_acc_we;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_wdata;

   // Round-robin search over core requests starting at the pointer
   always_comb begin
      w_found = 1'b0;
      w_win   = r_rr_ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!w_found && req[r_rr_ptr + i[1:0]]) begin
            w_found = 1'b1;
            w_win   = r_rr_ptr + i[1:0];
         end
      end
   end

   // Select the winning core's write flag, address and write data
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (w_win == k[1:0]) begin
            w_sel_we    = we[k];
            w_sel_addr  = addr_bus[k*ADDR_W +: ADDR_W];
            w_sel_wdata = wdata_bus[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef DMEM_ARB_TB_PORT_EN
   assign w_tb_win    = tb_req;
   assign w_acc_we    = tb_req ? tb_we    : w_sel_we;
   assign w_acc_addr  = tb_req ? tb_addr  : w_sel_addr;
   assign w_acc_wdata = tb_req ? tb_wdata : w_sel_wdata;
   assign tb_gnt      = (r_state == S_ACCESS) && r_is_tb;
   assign tb_rvalid   = r_tb_rvalid;
`else
   logic w_unused_tb;
   assign w_unused_tb = ^{tb_req, tb_we, tb_addr, tb_wdata, r_tb_rvalid};
   assign w_tb_win    = 1'b0;
   assign w_acc_we    = w_sel_we;
   assign w_acc_addr  = w_sel_addr;
   assign w_acc_wdata = w_sel_wdata;
   assign tb_gnt      = 1'b0;
   assign tb_rvalid   = 1'b0;
`endif

   // Transaction FSM: latch winner in IDLE, strobe memory in ACCESS,
   // capture read data and schedule the completion pulse in RESP
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= 2'd0;
         r_id        <= 2'd0;
         r_is_tb     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_rvalid    <= '0;
         r_tb_rvalid <= 1'b0;
      end else begin
         r_rvalid    <= '0;
         r_tb_rvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_tb_win || w_found) begin
                  r_state <= S_ACCESS;
                  r_is_tb <= w_tb_win;
                  r_we    <= w_acc_we;
                  r_addr  <= w_acc_addr;
                  r_wdata <= w_acc_wdata;
                  // a testbench win leaves the core pointer untouched
                  if (!w_tb_win) begin
                     r_id     <= w_win;
                     r_rr_ptr <= w_win + 2'd1;
                  end
               end
            end
            S_ACCESS: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
               if (!r_we) begin
                  r_rdata <= mem_rdata;
               end
               if (r_is_tb) begin
                  r_tb_rvalid <= 1'b1;
               end else begin
                  r_rvalid <= 4'b0001 << r_id;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt       = ((r_state == S_ACCESS) && !r_is_tb) ? (4'b0001 << r_id) : 4'b0000;
   assign mem_write = (r_state == S_ACCESS) && r_we;
   assign mem_read  = (r_state == S_ACCESS) && !r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign rvalid    = r_rvalid;
   assign rdata     = r_rdata;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single-core transactions,
// hand-written arbitration/reset sequences, and a completion scoreboard.
module tb_dmem_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic                clk = 1'b0;
   logic                RESET;
   logic [3:0]          req, we;
   logic [4*ADDR_W-1:0] addr_bus;
   logic [4*DATA_W-1:0] wdata_bus;
   logic [3:0]          gnt, rvalid;
   logic [DATA_W-1:0]   rdata;
   logic                tb_req, tb_we;
   logic [ADDR_W-1:0]   tb_addr;
   logic [DATA_W-1:0]   tb_wdata;
   logic                tb_gnt, tb_rvalid;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_write, mem_read;
   logic [DATA_W-1:0]   mem_rdata;
   logic                busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
   } exp_t;
   exp_t sb[$];
   logic [DATA_W-1:0] exp_hold;

   typedef struct {
      int          core;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] x;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
      .clk(clk), .RESET(RESET), .req(req), .we(we), .addr_bus(addr_bus),
      .wdata_bus(wdata_bus), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .tb_req(tb_req), .tb_we(tb_we), .tb_addr(tb_addr), .tb_wdata(tb_wdata),
      .tb_gnt(tb_gnt), .tb_rvalid(tb_rvalid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Data memory model: one-cycle read latency
   logic [DATA_W-1:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_gnt"}, {28'd0, gnt}, 0);
      check({nm, "_rvalid"}, {28'd0, rvalid}, 0);
      check({nm, "_rdata"}, {16'd0, rdata}, 0);
      check({nm, "_busy"}, {31'd0, busy}, 0);
      check({nm, "_mem_write"}, {31'd0, mem_write}, 0);
      check({nm, "_mem_read"}, {31'd0, mem_read}, 0);
      check({nm, "_mem_addr"}, {16'd0, mem_addr}, 0);
      check({nm, "_mem_wdata"}, {16'd0, mem_wdata}, 0);
      check({nm, "_tb_gnt"}, {31'd0, tb_gnt}, 0);
      check({nm, "_tb_rvalid"}, {31'd0, tb_rvalid}, 0);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      req = '0;
      tb_req = 1'b0;
      @(negedge clk);
      check("sb_drained", sb.size(), 0);
      sb.delete();
      exp_hold = '0;
      RESET = 1'b1;
   endtask

   task automatic wait_grant(input string nm, output logic [4:0] g, output int t);
      g = '0;
      t = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if ({tb_gnt, gnt} != 5'd0) begin
            g = {tb_gnt, gnt};
            t = cyc;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no grant in 6 cycles, required a grant", nm);
   endtask

   task automatic set_core(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
      we[k] = w;
      addr_bus[k*ADDR_W +: ADDR_W] = a;
      wdata_bus[k*DATA_W +: DATA_W] = d;
   endtask

   // Completion monitor: every rvalid/tb_rvalid pops the scoreboard
   always @(negedge clk) begin : mon
      int id;
      exp_t e;
      check("gnt_onehot", {31'd0, $countones({tb_gnt, gnt}) <= 1}, 1);
      check("rvalid_onehot", {31'd0, $countones({tb_rvalid, rvalid}) <= 1}, 1);
      if (rvalid != 4'd0 || tb_rvalid) begin
         case (rvalid)
            4'b0001: id = 0;
            4'b0010: id = 1;
            4'b0100: id = 2;
            4'b1000: id = 3;
            default: id = tb_rvalid ? 4 : 9;
         endcase
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rvalid: got id %0d, required no completion", id);
         end else begin
            e = sb.pop_front();
            check("rvalid_id", id, e.id);
            check("rdata", {16'd0, rdata}, {16'd0, e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] g;
      int t, t_prev, t0;
      int order[4];

      vt[0] = '{1, 1'b1, 16'h0010, 16'hABCD, 16'h0000};
      vt[1] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
      vt[2] = '{0, 1'b1, 16'h0020, 16'h1234, 16'h0000};
      vt[3] = '{3, 1'b1, 16'h0011, 16'h5555, 16'h0000};
      vt[4] = '{2, 1'b0, 16'h0020, 16'h0000, 16'h1234};
      vt[5] = '{0, 1'b0, 16'h0011, 16'h0000, 16'h5555};
      vt[6] = '{3, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
      vt[7] = '{2, 1'b1, 16'h0010, 16'h0F0F, 16'h0000};

      RESET = 1'b0; req = '0; we = '0; addr_bus = '0; wdata_bus = '0;
      tb_req = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
      exp_hold = '0;
      @(negedge clk);
      check_all_zero("reset");
      do_reset();

      // Table-driven back-to-back single-core transactions
      for (int v = 0; v < 8; v++) begin
         set_core(vt[v].core, vt[v].w, vt[v].a, vt[v].d);
         req[vt[v].core] = 1'b1;
         check("idle_busy", {31'd0, busy}, 0);
         @(negedge clk);
         check("t1_gnt", {28'd0, gnt}, 32'(1) << vt[v].core);
         check("t1_mem_write", {31'd0, mem_write}, {31'd0, vt[v].w});
         check("t1_mem_read", {31'd0, mem_read}, {31'd0, !vt[v].w});
         check("t1_mem_addr", {16'd0, mem_addr}, {16'd0, vt[v].a});
         if (vt[v].w) check("t1_mem_wdata", {16'd0, mem_wdata}, {16'd0, vt[v].d});
         check("t1_busy", {31'd0, busy}, 1);
         if (!vt[v].w) exp_hold = vt[v].x;
         sb.push_back('{vt[v].core, exp_hold});
         req[vt[v].core] = 1'b0;
         @(negedge clk);
         check("t2_gnt", {28'd0, gnt}, 0);
         check("t2_strobes", {30'd0, mem_write, mem_read}, 0);
         check("t2_mem_addr_hold", {16'd0, mem_addr}, {16'd0, vt[v].a});
         @(negedge clk);
         check("t3_rvalid", {28'd0, rvalid}, 32'(1) << vt[v].core);
         check("t3_busy", {31'd0, busy}, 0);
      end
      repeat (2) @(negedge clk);

      // All four cores requesting: grants 0,1,2,3 three cycles apart
      do_reset();
      for (int k = 0; k < 4; k++) set_core(k, 1'b1, 16'h0030 + 16'(k), 16'h1000 + 16'(k));
      req = 4'b1111;
      t0 = cyc;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_grant("rr4", g, t);
         check("rr4_gnt", {27'd0, g}, 32'(1) << k);
         if (k == 0) check("rr4_latency", t - t0, 1);
         else        check("rr4_spacing", t - t_prev, 3);
         t_prev = t;
         sb.push_back('{k, exp_hold});
         req[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rr4_sb_empty", sb.size(), 0);

      // Cores 0 and 2 hold requests: grants alternate 0,2,0,2
      do_reset();
      set_core(0, 1'b1, 16'h0040, 16'hAAAA);
      set_core(2, 1'b1, 16'h0042, 16'hBBBB);
      req = 4'b0101;
      order = '{0, 2, 0, 2};
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_grant("alt", g, t);
         check("alt_gnt", {27'd0, g}, 32'(1) << order[k]);
         if (k > 0) check("alt_spacing", t - t_prev, 3);
         t_prev = t;
         sb.push_back('{order[k], exp_hold});
      end
      req = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("alt_no_more_gnt", {27'd0, tb_gnt, gnt}, 0);
      end
      check("alt_sb_empty", sb.size(), 0);

      // Testbench port competing with core 3
      do_reset();
      tb_we = 1'b1; tb_addr = 16'h0050; tb_wdata = 16'h7777;
      set_core(3, 1'b1, 16'h0051, 16'h2222);
      tb_req = 1'b1;
      req = 4'b1000;
`ifdef DMEM_ARB_TB_PORT_EN
      wait_grant("tbp_first", g, t);
      check("tbp_first_gnt", {27'd0, g}, 32'h10);
      sb.push_back('{4, exp_hold});
      tb_req = 1'b0;
      t_prev = t;
      wait_grant("tbp_second", g, t);
      check("tbp_second_gnt", {27'd0, g}, 32'h08);
      check("tbp_spacing", t - t_prev, 3);
      sb.push_back('{3, exp_hold});
      req = '0;
      repeat (3) @(negedge clk);
`else
      wait_grant("tbp_core3", g, t);
      check("tbp_core3_gnt", {27'd0, g}, 32'h08);
      sb.push_back('{3, exp_hold});
      req = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("tbp_tb_gnt_low", {31'd0, tb_gnt}, 0);
         check("tbp_tb_rvalid_low", {31'd0, tb_rvalid}, 0);
      end
      tb_req = 1'b0;
`endif
      check("tbp_sb_empty", sb.size(), 0);

      // Reset during the ACCESS cycle of a core 2 read aborts it
      do_reset();
      set_core(2, 1'b0, 16'h0010, 16'h0000);
      req = 4'b0100;
      wait_grant("abort", g, t);
      check("abort_gnt", {27'd0, g}, 32'h04);
      check("abort_mem_read_before", {31'd0, mem_read}, 1);
      #2 RESET = 1'b0;
      #1 check_all_zero("abort");
      req = '0;
      @(negedge clk);
      RESET = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_no_rvalid", {28'd0, rvalid}, 0);
         check("abort_no_read", {31'd0, mem_read}, 0);
         check("abort_no_gnt", {28'd0, gnt}, 0);
      end
      check("final_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
